// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and helpers for the MIPS memory-access stage.
//   mem_state_e : access FSM states (IDLE, FILL, STORE, RESP)
//   line_t      : one cache line as seen on the array read port
//                 (valid, tag zero-extended to TAG_W_MAX, four data bytes,
//                 data[3] = bits 31:24 ... data[0] = bits 7:0)
//   WORD_BYTES  : bytes per word / per cache line
//   calc_wbe()  : memory byte enables for a store
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_BYTES = 4;

    // Widest possible tag (INDEX_BITS = 0); narrower tags are zero-extended.
    localparam int TAG_W_MAX = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        STORE = 2'd2,
        RESP  = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic                       valid;
        logic [TAG_W_MAX-1:0]       tag;
        logic [WORD_BYTES-1:0][7:0] data;
    } line_t;

    // Byte number 0 is the most significant lane (big-endian), so a byte
    // store enables lane 3 - byte_number.
    function automatic logic [WORD_BYTES-1:0] calc_wbe(input logic       is_word,
                                                       input logic [1:0] byte_number);
        logic [WORD_BYTES-1:0] wbe;
        if (is_word) begin
            wbe = 4'b1111;
        end else begin
            case (byte_number)
                2'd0:    wbe = 4'b1000;
                2'd1:    wbe = 4'b0100;
                2'd2:    wbe = 4'b0010;
                default: wbe = 4'b0001;
            endcase
        end
        return wbe;
    endfunction

endpackage

// File: rtl/mem_access_stage_dcache_array.sv
// -----------------------------------------------------------------------------
// dcache_array
// Tag, valid and data storage of the direct-mapped data cache
// (2**INDEX_BITS one-word lines).
//   clk       in   clock
//   rst_b     in   synchronous active-low reset, clears every valid bit
//   rd_index  in   line to read (combinational read port)
//   rd_line   out  valid, tag and data of that line
//   wr_en     in   write strobe; marks the line valid and writes its tag
//   wr_index  in   line to write
//   wr_tag    in   tag to store
//   wr_be     in   byte enables, bit 3 = bits 31:24
//   wr_data   in   write data, [3] = bits 31:24
// Tags and data are not reset; the valid bits alone gate their use.
// -----------------------------------------------------------------------------
module dcache_array
    import mem_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 30 - INDEX_BITS
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic [INDEX_BITS-1:0]      rd_index,
    output line_t                      rd_line,
    input  logic                       wr_en,
    input  logic [INDEX_BITS-1:0]      wr_index,
    input  logic [TAG_W-1:0]           wr_tag,
    input  logic [WORD_BYTES-1:0]      wr_be,
    input  logic [WORD_BYTES-1:0][7:0] wr_data
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [DEPTH-1:0]           valid_q;
    logic [TAG_W-1:0]           tag_q  [DEPTH];
    logic [WORD_BYTES-1:0][7:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (wr_be[b]) begin
                    data_q[wr_index][b] <= wr_data[b];
                end
            end
        end
    end

    always_comb begin
        rd_line       = '0;
        rd_line.valid = valid_q[rd_index];
        rd_line.tag   = TAG_W_MAX'(tag_q[rd_index]);
        rd_line.data  = data_q[rd_index];
    end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the MIPS core, between EX and WB. Loads and stores from EX go
// through a direct-mapped, write-through, no-write-allocate data cache backed
// by a request/ack memory port. The accessed word is handed to WB as four
// bytes plus the byte offset; WB does byte selection and sign extension.
//
// Build option: MEM_DCACHE_EN
//   defined   - cache array present; read hits complete with no stall.
//   undefined - no array; every load fills from memory and the returned word
//               is held in a register for the RESP cycle.
//
// Ports
//   clk             in   clock
//   rst_b           in   synchronous active-low reset
//   mem_read        in   load request
//   mem_write       in   store request (wins over mem_read)
//   is_word         in   1 = word access, 0 = byte access
//   addr            in   byte address
//   store_data      in   store data (byte stores use [7:0])
//   cache_data_out  out  accessed word, [3] = bits 31:24 ... [0] = bits 7:0
//   byte_number     out  addr[1:0], 0 selects [3]
//   stall           out  freezes PC and pipeline registers up to EX/MEM
//   mem_req         out  memory request
//   mem_we          out  memory write strobe
//   mem_addr        out  word-aligned memory address
//   mem_wdata       out  memory write data
//   mem_wbe         out  memory byte enables, bit 3 = bits 31:24
//   mem_rdata       in   memory read data
//   mem_ack         in   one-cycle completion pulse
// -----------------------------------------------------------------------------
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic                       is_word,
    input  logic [31:0]                addr,
    input  logic [31:0]                store_data,
    output logic [WORD_BYTES-1:0][7:0] cache_data_out,
    output logic [1:0]                 byte_number,
    output logic                       stall,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [WORD_BYTES-1:0]      mem_wbe,
    input  logic [31:0]                mem_rdata,
    input  logic                       mem_ack
);

    localparam int TAG_W = 30 - INDEX_BITS;

    mem_state_e                 state_q;
    mem_state_e                 state_d;
    logic [TAG_W-1:0]           addr_tag;
    logic [INDEX_BITS-1:0]      addr_index;
    logic [WORD_BYTES-1:0]      store_wbe;
    logic [WORD_BYTES-1:0][7:0] store_lanes;
    logic                       read_hit;
    logic [WORD_BYTES-1:0][7:0] line_word;

    assign addr_tag    = addr[31:INDEX_BITS+2];
    assign addr_index  = addr[INDEX_BITS+1:2];
    assign byte_number = addr[1:0];
    assign store_wbe   = calc_wbe(is_word, addr[1:0]);
    // A byte store drives its byte on every lane; mem_wbe picks the lane.
    assign store_lanes = is_word ? store_data : {WORD_BYTES{store_data[7:0]}};

`ifdef MEM_DCACHE_EN
    line_t                      rd_line;
    logic                       arr_wr_en;
    logic [WORD_BYTES-1:0]      arr_wr_be;
    logic [WORD_BYTES-1:0][7:0] arr_wr_data;

    assign read_hit = rd_line.valid && (rd_line.tag == TAG_W_MAX'(addr_tag));

    // Fills install the whole line; store acks merge only into a line that
    // already holds this address (no write-allocate).
    assign arr_wr_en   = rst_b && mem_ack &&
                         ((state_q == FILL) || ((state_q == STORE) && read_hit));
    assign arr_wr_be   = (state_q == FILL) ? {WORD_BYTES{1'b1}} : store_wbe;
    assign arr_wr_data = (state_q == FILL) ? mem_rdata : store_lanes;

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_dcache_array (
        .clk      (clk),
        .rst_b    (rst_b),
        .rd_index (addr_index),
        .rd_line  (rd_line),
        .wr_en    (arr_wr_en),
        .wr_index (addr_index),
        .wr_tag   (addr_tag),
        .wr_be    (arr_wr_be),
        .wr_data  (arr_wr_data)
    );

    // Inputs are held during the stall, so in RESP the read port still points
    // at the line that was just installed or merged.
    assign line_word = rd_line.data;
`else
    logic [WORD_BYTES-1:0][7:0] fill_word_q;

    always_ff @(posedge clk) begin
        if ((state_q == FILL) && mem_ack) begin
            fill_word_q <= mem_rdata;
        end
    end

    assign read_hit  = 1'b0;
    assign line_word = fill_word_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        stall          = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_wbe        = '0;
        cache_data_out = '0;

        case (state_q)
            IDLE: begin
                if (mem_write) begin
                    stall   = 1'b1;
                    state_d = STORE;
                end else if (mem_read) begin
                    if (read_hit) begin
                        cache_data_out = line_word;
                    end else begin
                        stall   = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {addr_tag, addr_index, 2'b00};
                if (mem_ack) begin
                    state_d = RESP;
                end
            end
            STORE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_tag, addr_index, 2'b00};
                mem_wdata = store_lanes;
                mem_wbe   = store_wbe;
                if (mem_ack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cache_data_out = line_word;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are held quiet for as long as reset is asserted, even if the
        // state register has not yet been returned to IDLE.
        if (!rst_b) begin
            stall          = 1'b0;
            mem_req        = 1'b0;
            mem_we         = 1'b0;
            mem_addr       = '0;
            mem_wdata      = '0;
            mem_wbe        = '0;
            cache_data_out = '0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
module tb_mem_access_stage;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             mem_read;
    logic             mem_write;
    logic             is_word;
    logic [31:0]      addr;
    logic [31:0]      store_data;
    logic [3:0][7:0]  cache_data_out;
    logic [1:0]       byte_number;
    logic             stall;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wbe;
    logic [31:0]      mem_rdata;
    logic             mem_ack;

    mem_access_stage #(.INDEX_BITS(4)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .is_word        (is_word),
        .addr           (addr),
        .store_data     (store_data),
        .cache_data_out (cache_data_out),
        .byte_number    (byte_number),
        .stall          (stall),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wbe        (mem_wbe),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Backing memory, word-addressed by aligned byte address.
    logic [31:0] mem_model [logic [31:0]];

    // Observations collected by one access.
    int          st_cyc;
    int          rq_cyc;
    logic        done;
    logic [31:0] resp_word;
    logic        resp_req;
    logic        seen_we;
    logic        rd_req_seen;
    logic [3:0]  seen_wbe;
    logic [31:0] seen_wdata;
    logic [31:0] seen_addr;
    logic [1:0]  seen_bn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        w = mem_model.exists(a) ? mem_model[a] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        mem_model[a] = w;
    endtask

    // Called just after a falling edge. Holds the request until the stage
    // stops stalling, acking the lat-th cycle of mem_req, then drops it.
    task automatic access(input string tag, input logic rd, input logic wr, input logic word,
                          input logic [31:0] a, input logic [31:0] sd, input int lat);
        st_cyc = 0; rq_cyc = 0; done = 1'b0; resp_word = '0; resp_req = 1'b0;
        seen_we = 1'b0; rd_req_seen = 1'b0; seen_wbe = '0; seen_wdata = '0; seen_addr = '0;
        mem_read = rd; mem_write = wr; is_word = word; addr = a; store_data = sd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (c == 0) seen_bn = byte_number;
            if (!stall) begin
                done      = 1'b1;
                resp_word = cache_data_out;
                resp_req  = mem_req;
            end else begin
                st_cyc++;
                if (mem_req) begin
                    rq_cyc++;
                    seen_addr = mem_addr;
                    if (mem_we) begin
                        seen_we    = 1'b1;
                        seen_wbe   = mem_wbe;
                        seen_wdata = mem_wdata;
                    end else begin
                        rd_req_seen = 1'b1;
                    end
                    if (rq_cyc == lat) begin
                        mem_ack   = 1'b1;
                        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                        if (mem_we) model_write(mem_addr, mem_wdata, mem_wbe);
                    end
                end
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = '0;
                @(negedge clk);
            end
        end
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_model[32'h0000_0040] = 32'hDEADBEEF;
        mem_model[32'h0000_00C0] = 32'h0BADF00D;

        // Reset with a store request present: everything must stay quiet.
        rst_b = 1'b0; mem_read = 1'b1; mem_write = 1'b1; is_word = 1'b1;
        addr = 32'h0000_0042; store_data = 32'hFFFF_FFFF;
        mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_wbe", mem_wbe, 4'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_cdo", cache_data_out, 32'h0);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; mem_rdata = '0; rst_b = 1'b1;
        @(negedge clk);

        // Cold word load, 3-cycle memory.
        access("cold", 1, 0, 1, 32'h0000_0040, 32'h0, 3);
        check("cold_stall", st_cyc, 4);
        check("cold_req", rq_cyc, 3);
        check("cold_data", resp_word, 32'hDEADBEEF);
        check("cold_addr", seen_addr, 32'h0000_0040);
        check("cold_we", seen_we, 1'b0);
        check("cold_req_resp", resp_req, 1'b0);
        check("cold_bn", seen_bn, 2'd0);

        // Repeat load of the same word.
        access("rep", 1, 0, 1, 32'h0000_0040, 32'h0, 3);
`ifdef MEM_DCACHE_EN
        check("rep_stall", st_cyc, 0);
        check("rep_req", rq_cyc, 0);
`else
        check("rep_stall", st_cyc, 4);
        check("rep_req", rq_cyc, 3);
`endif
        check("rep_data", resp_word, 32'hDEADBEEF);

        // Byte store 0xAA to 0x42: lane 1 (bits 15:8).
        access("bst", 0, 1, 0, 32'h0000_0042, 32'h0000_00AA, 3);
        check("bst_stall", st_cyc, 4);
        check("bst_req", rq_cyc, 3);
        check("bst_we", seen_we, 1'b1);
        check("bst_wbe", seen_wbe, 4'b0010);
        check("bst_wdata", seen_wdata, 32'hAAAAAAAA);
        check("bst_addr", seen_addr, 32'h0000_0040);
        check("bst_bn", seen_bn, 2'd2);
`ifdef MEM_DCACHE_EN
        check("bst_resp", resp_word, 32'hDEADAAEF);
`endif

        // Word load of the merged line.
        access("ldm", 1, 0, 1, 32'h0000_0040, 32'h0, 3);
`ifdef MEM_DCACHE_EN
        check("ldm_stall", st_cyc, 0);
`else
        check("ldm_stall", st_cyc, 4);
`endif
        check("ldm_data", resp_word, 32'hDEADAAEF);

        // Word store to an uncached address, then a load of it must fill.
        access("wst", 0, 1, 1, 32'h0000_0080, 32'h12345678, 3);
        check("wst_stall", st_cyc, 4);
        check("wst_req", rq_cyc, 3);
        check("wst_wbe", seen_wbe, 4'b1111);
        check("wst_wdata", seen_wdata, 32'h12345678);
        check("wst_addr", seen_addr, 32'h0000_0080);
        access("ld80", 1, 0, 1, 32'h0000_0080, 32'h0, 3);
        check("ld80_fill", rd_req_seen, 1'b1);
        check("ld80_req", rq_cyc, 3);
        check("ld80_data", resp_word, 32'h12345678);

        // Reset in the middle of a fill; the late ack must be ignored.
        mem_read = 1'b1; is_word = 1'b1; addr = 32'h0000_00C0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("mf_req_on", mem_req, 1'b1);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        check("mf_req_rst", mem_req, 1'b0);
        check("mf_stall_rst", stall, 1'b0);
        @(negedge clk);
        rst_b = 1'b1; mem_read = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        mem_ack = 1'b0; mem_rdata = '0;
        check("mf_req_ack", mem_req, 1'b0);
        check("mf_stall_ack", stall, 1'b0);
        @(negedge clk);
        access("post", 1, 0, 1, 32'h0000_0040, 32'h0, 3);
        check("post_req", rq_cyc, 3);
        check("post_stall", st_cyc, 4);
        check("post_data", resp_word, 32'hDEADAAEF);

        // Read and write together act as a store; 1-cycle memory.
        access("rw", 1, 1, 1, 32'h0000_0040, 32'hCAFEF00D, 1);
        check("rw_we", seen_we, 1'b1);
        check("rw_nofill", rd_req_seen, 1'b0);
        check("rw_req", rq_cyc, 1);
        check("rw_stall", st_cyc, 2);
        check("rw_wbe", seen_wbe, 4'b1111);
        access("fin", 1, 0, 1, 32'h0000_0040, 32'h0, 1);
`ifdef MEM_DCACHE_EN
        check("fin_stall", st_cyc, 0);
`else
        check("fin_stall", st_cyc, 2);
`endif
        check("fin_data", resp_word, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
